// File: rtl/tiny_rr_arbiter.sv
// 2-to-1 round-robin arbiter sharing one registered valid/ready write port,
// with per-requester saturating accepted-beat counters for debug.
module tiny_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic [ADDR_W-1:0] s1_addr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_src,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   can_load;
  logic   grant;
  logic   accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    can_load = rst_n & ((state == EMPTY) | m_ready);
  end

  always_comb begin
    grant = 1'b0;
    if (s0_valid && s1_valid) grant = ~last_grant;
    else if (s1_valid)        grant = 1'b1;
  end

  always_comb begin
    s0_ready = can_load & s0_valid & ~grant;
    s1_ready = can_load & s1_valid & grant;
    accept   = s0_ready | s1_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (can_load) state_nxt = accept ? FULL : EMPTY;
  end

  always_comb begin
    m_valid = (state == FULL);
  end

  // Output register: loaded only on accept, otherwise holds its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data     <= '0;
      m_addr     <= '0;
      m_src      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      m_data     <= grant ? s1_data : s0_data;
      m_addr     <= grant ? s1_addr : s0_addr;
      m_src      <= grant;
      last_grant <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (s0_ready) cnt0 <= sat_inc(cnt0);
      if (s1_ready) cnt1 <= sat_inc(cnt1);
    end
  end

endmodule

// File: tb/tb_tiny_rr_arbiter.sv
// Directed bench for tiny_rr_arbiter (CNT_W=4 so counter saturation is reachable).
module tb_tiny_rr_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s0_valid, s1_valid;
  logic              s0_ready, s1_ready;
  logic [DATA_W-1:0] s0_data, s1_data;
  logic [ADDR_W-1:0] s0_addr, s1_addr;
  logic              m_valid, m_ready, m_src;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt0, cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  tiny_rr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_addr(s0_addr),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_addr(s1_addr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .m_src(m_src),
    .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; m_ready = 1'b1; cnt_clr = 1'b0;
    s0_valid = 1'b1; s1_valid = 1'b1;
    s0_data = 32'h0000_0011; s0_addr = 32'h0000_1000;
    s1_data = 32'h0000_0022; s1_addr = 32'h0000_2000;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    tick();
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_src", m_src, 0);

    // Only s1 valid right after reset: granted despite last_grant=1.
    rst_n = 1'b1; s0_valid = 1'b0;
    s1_data = 32'h0000_5151; s1_addr = 32'h0000_1111;
    #1;
    chk("only1_s0_ready", s0_ready, 0);
    chk("only1_s1_ready", s1_ready, 1);
    tick();
    chk("only1_m_valid", m_valid, 1);
    chk("only1_m_src", m_src, 1);
    chk("only1_m_data", m_data, 32'h0000_5151);
    chk("only1_cnt1", cnt1, 1);

    // Single requester s0, one-cycle latency.
    s1_valid = 1'b0; s0_valid = 1'b1;
    s0_addr = 32'h2000_0010; s0_data = 32'hA5A5_0001;
    #1;
    chk("single_s0_ready", s0_ready, 1);
    chk("single_s1_ready", s1_ready, 0);
    tick();
    chk("single_m_valid", m_valid, 1);
    chk("single_m_addr", m_addr, 32'h2000_0010);
    chk("single_m_data", m_data, 32'hA5A5_0001);
    chk("single_m_src", m_src, 0);
    chk("single_cnt0", cnt0, 1);

    // Drain: no requests, beat consumed, payload holds.
    s0_valid = 1'b0;
    s0_data = 32'hFFFF_FFFF; s0_addr = 32'hFFFF_FFFF;
    #1;
    chk("drain_s0_ready", s0_ready, 0);
    chk("drain_s1_ready", s1_ready, 0);
    tick();
    chk("drain_m_valid", m_valid, 0);
    chk("drain_m_addr", m_addr, 32'h2000_0010);
    chk("drain_m_data", m_data, 32'hA5A5_0001);
    chk("drain_m_src", m_src, 0);

    // s1 accept coinciding with clear: clear wins; leaves last_grant=1.
    s1_valid = 1'b1; s1_data = 32'h0000_0777; cnt_clr = 1'b1;
    tick();
    chk("clr_acc_cnt1", cnt1, 0);
    chk("clr_acc_cnt0", cnt0, 0);
    chk("clr_acc_m_src", m_src, 1);
    cnt_clr = 1'b0;

    // Fairness: both valid for 8 cycles -> 0,1,0,1...
    s0_valid = 1'b1; s1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s0_data = 32'h100 + i; s1_data = 32'h200 + i;
      #1;
      chk("fair_s0_ready", s0_ready, (i % 2) == 0);
      chk("fair_s1_ready", s1_ready, (i % 2) == 1);
      tick();
      chk("fair_m_valid", m_valid, 1);
      chk("fair_m_src", m_src, i % 2);
      chk("fair_m_data", m_data, ((i % 2) == 1) ? 32'h200 + i : 32'h100 + i);
    end
    chk("fair_cnt0", cnt0, 4);
    chk("fair_cnt1", cnt1, 4);

    // Backpressure: beat from s1 (0x207) pending for 5 cycles.
    m_ready = 1'b0;
    s0_data = 32'hDEAD_0000; s0_addr = 32'h3000_0000;
    s1_data = 32'hBEEF_0000; s1_addr = 32'h4000_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_s0_ready", s0_ready, 0);
      chk("bp_s1_ready", s1_ready, 0);
      tick();
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_src", m_src, 1);
      chk("bp_m_data", m_data, 32'h207);
    end
    m_ready = 1'b1;
    #1;
    chk("bp_rel_s0_ready", s0_ready, 1);
    chk("bp_rel_s1_ready", s1_ready, 0);
    tick();
    chk("bp_rel_m_src", m_src, 0);
    chk("bp_rel_m_data", m_data, 32'hDEAD_0000);
    chk("bp_rel_m_addr", m_addr, 32'h3000_0000);
    chk("bp_cnt0", cnt0, 5);
    chk("bp_cnt1", cnt1, 4);

    // Saturation: 20 more s1 accepts from 4 -> sticks at 15.
    s0_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt1", cnt1, 15);
    chk("sat_cnt0", cnt0, 5);
    cnt_clr = 1'b1;
    #1;
    chk("satclr_s1_ready", s1_ready, 1);
    tick();
    chk("satclr_cnt1", cnt1, 0);
    chk("satclr_cnt0", cnt0, 0);
    cnt_clr = 1'b0;
    tick();
    chk("post_clr_cnt1", cnt1, 1);

    // Mid-operation async reset drops the in-flight beat immediately.
    s1_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_cnt1", cnt1, 0);
    tick();
    rst_n = 1'b1; s0_valid = 1'b1; s1_valid = 1'b1;
    s0_data = 32'h0000_AAAA; s1_data = 32'h0000_BBBB;
    #1;
    chk("midrst_s0_ready", s0_ready, 1);
    chk("midrst_s1_ready", s1_ready, 0);
    tick();
    chk("midrst_m_src", m_src, 0);
    chk("midrst_m_data2", m_data, 32'h0000_AAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
